prog_delay_line: RTL and testbench
==================================

# prog_delay_line

Parametrised, multi-channel, runtime-programmable register delay line. It carries C independent W-bit channels through a shared chain of up to N nonblocking-update stages, with a per-sample valid bit, a clock enable (stall), and a delay that can be reloaded at run time. It is the general form of our fixed three-register synchroniser/delay chains. It sits between a sample source and any consumer that needs channel-aligned, cycle-exact delayed data, for example pipeline balancing in the video and DSP paths.

## Interface
Parameters:
- W, 8: data width per channel
- C, 3: channel count
- N, 16: maximum delay in stages (N ≥ 2)
- DLY_RST, 3: delay in effect after reset (1..N)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  stage enable; when low, all state holds
- din  in  C*W  input samples; channel k occupies bits [k*W +: W]
- din_valid  in  1  input sample valid
- dly  in  $clog2(N+1)  requested delay, sampled only when dly_ld = 1
- dly_ld  in  1  single-cycle pulse that loads dly
- dout  out  C*W  delayed samples, same packing as din
- dout_valid  out  1  dout holds a valid sample
- busy  out  1  the line is refilling after a delay load
- dly_cur  out  $clog2(N+1)  delay currently in effect

## Operation
- Storage: stage s = 0..N-1 per channel, plus a valid bit vld[s].
- On a clock edge with en = 1:
  - stage[0] <= din and vld[0] <= din_valid.
  - stage[s] <= stage[s-1] and vld[s] <= vld[s-1].
  - All stages update concurrently with nonblocking semantics. Order of statements must not matter.
- Output tap: dout = stage[dly_cur-1] and dout_valid = vld[dly_cur-1] & ~busy. Both are a mux of registered state, with no combinational path from din.
- Delay load:
  - When dly_ld = 1, dly_cur <= clamp(dly), where values of 0 map to 1 and values greater than N map to N.
  - On the same edge, all vld bits clear (including the sample arriving that cycle), and the fill counter cnt <= clamp(dly).
  - Data registers are not cleared.
  - dly_ld acts regardless of en.
- Fill counter:
  - busy = (cnt != 0).
  - cnt decrements by 1 on each edge with en = 1 and dly_ld = 0, saturating at 0.
- Simultaneous events:
  - When dly_ld and en are both 1, data shifts, and the valid clear and counter load take priority.
  - dly_ld during busy restarts the fill with the new value.
- Reset: all stage data 0, all vld 0, dly_cur = DLY_RST, cnt = 0. Therefore dout = 0, dout_valid = 0, busy = 0, dly_cur = DLY_RST.
- Reset asserted mid-stream discards all in-flight samples immediately (asynchronous reset).

## Timing
- Latency: a sample accepted at en-edge E appears on dout, with dout_valid set, after edge E+dly_cur-1 (the dly_cur-th en-edge counting E). With dly_cur = 3, a sample accepted at edge 1 is visible after edge 3.
- Throughput: one sample per en cycle. Gaps from en = 0 stretch latency in clock cycles, not in en cycles.
- After a load of d, busy stays high for exactly d en-edges. The first dout_valid can occur on the cycle busy falls, for a sample accepted on the first en-edge after the load.
- All channels stay cycle-aligned at all times.

## Structure
- Package prog_delay_pkg holds:
  - the function clamp_dly(val, N)
  - a localparam helper for the width $clog2(N+1)
- Sub-module delay_chan: one W-bit, N-stage shift register with en and a tap index, instantiated C times via generate.
- The valid chain, fill counter, dly_cur register and busy logic live in prog_delay_line.

## Test plan
- Default delay: after reset, en = 1, push ch0 = 0x11, 0x22, 0x33 with valid. Required: dout ch0 = 0x11 with dout_valid = 1 three edges after 0x11 is accepted, then 0x22 and 0x33 on consecutive cycles. dly_cur = 3.
- Stall: same stream with en = 0 for 4 cycles mid-stream. Required: dout and dout_valid frozen during the stall, and no sample lost or duplicated.
- Reload to 16: pulse dly_ld with dly = 16. Required: busy high for 16 en-edges, dout_valid = 0 throughout. A sample of 0xA5 on all C channels, accepted on the first edge after the load, then emerges with valid on the cycle busy falls.
- Clamping: dly = 0 gives dly_cur = 1 and one-edge latency. dly = 20 with N = 16 gives dly_cur = 16.
- Load collision: dly_ld together with din_valid = 1 and din = 0x7E. Required: 0x7E is never presented with dout_valid = 1.
- Reset mid-stream: drop reset_n while 5 samples are in flight. Required: dout = 0, dout_valid = 0 and busy = 0 immediately. After release, dly_cur = DLY_RST and the next stream behaves as in the first scenario.

Source files
------------

// File: rtl/prog_delay_pkg.sv
// prog_delay_pkg: shared delay-width helper and delay clamping for prog_delay_line.
package prog_delay_pkg;
  function automatic int unsigned dly_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction
  function automatic int unsigned clamp_dly(input int unsigned val, input int unsigned n);
    return (val == 0) ? 1 : (val > n) ? n : val;
  endfunction
endpackage

// File: rtl/prog_delay_line_chan.sv
// delay_chan: one W-bit, N-stage shift register with a selectable output tap.
module delay_chan
  import prog_delay_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [W-1:0]         d,
  input  logic [$clog2(N)-1:0] tap,
  output logic [W-1:0]         q
);
  logic [N-1:0][W-1:0] stage_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stage_q <= '0;
    else if (en) stage_q <= {stage_q[N-2:0], d};
  end
  assign q = stage_q[tap];
endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: C-channel programmable delay line with valid tracking and refill-after-reload.
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int W       = 8,
  parameter int C       = 3,
  parameter int N       = 16,
  parameter int DLY_RST = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [C*W-1:0]        din,
  input  logic                  din_valid,
  input  logic [dly_w(N)-1:0]   dly,
  input  logic                  dly_ld,
  output logic [C*W-1:0]        dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic [dly_w(N)-1:0]   dly_cur
);
  localparam int DW = dly_w(N);
  localparam int TW = $clog2(N);
  logic [DW-1:0] dly_cur_q, dly_cur_d, cnt_q, cnt_d, dly_new;
  logic [N-1:0]  vld_q, vld_d;
  logic [TW-1:0] tap;
  // A load wins over the shift for valids and counter; data still shifts when enabled.
  always_comb begin
    dly_new   = DW'(clamp_dly(32'(dly), N));
    dly_cur_d = dly_ld ? dly_new : dly_cur_q;
    cnt_d     = dly_ld ? dly_new : (en && cnt_q != '0) ? cnt_q - DW'(1) : cnt_q;
    vld_d     = dly_ld ? '0 : en ? {vld_q[N-2:0], din_valid} : vld_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_cur_q <= DW'(DLY_RST);
      cnt_q     <= '0;
      vld_q     <= '0;
    end else begin
      dly_cur_q <= dly_cur_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
    end
  end
  assign tap        = TW'(dly_cur_q - DW'(1));
  assign busy       = cnt_q != '0;
  assign dout_valid = vld_q[tap] & ~busy;
  assign dly_cur    = dly_cur_q;
  for (genvar k = 0; k < C; k++) begin : g_chan
    delay_chan #(.W(W), .N(N)) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (en),
      .d      (din[k*W +: W]),
      .tap    (tap),
      .q      (dout[k*W +: W])
    );
  end
endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed scenarios plus random traffic against a sample-history model.
module tb_prog_delay_line;
  localparam int W = 8, C = 3, N = 16, DLY_RST = 3;
  localparam int CW = C * W;
  localparam int DW = $clog2(N + 1);
  logic          clk = 1'b0, reset_n = 1'b0, en = 1'b0, din_valid = 1'b0, dly_ld = 1'b0;
  logic [CW-1:0] din = '0;
  logic [DW-1:0] dly = '0;
  logic [CW-1:0] dout;
  logic          dout_valid, busy;
  logic [DW-1:0] dly_cur;
  prog_delay_line #(.W(W), .C(C), .N(N), .DLY_RST(DLY_RST)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .din(din), .din_valid(din_valid),
    .dly(dly), .dly_ld(dly_ld), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .dly_cur(dly_cur)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  // Model: every accepted sample in order; samples with index < inv_upto were killed by a load.
  logic [CW-1:0] hist_d[$];
  bit            hist_v[$];
  int            inv_upto = 0, m_cnt = 0, m_dly = DLY_RST;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int clampm(input int d);
    return d == 0 ? 1 : d > N ? N : d;
  endfunction
  function automatic logic [CW-1:0] rep(input logic [7:0] b);
    return {C{b}};
  endfunction
  task automatic model_reset();
    hist_d.delete();
    hist_v.delete();
    inv_upto = 0;
    m_cnt    = 0;
    m_dly    = DLY_RST;
  endtask
  task automatic check_outs();
    int            idx;
    logic [CW-1:0] ed;
    bit            ev;
    idx = hist_d.size() - m_dly;
    ed  = '0;
    ev  = 1'b0;
    if (idx >= 0) begin
      ed = hist_d[idx];
      ev = hist_v[idx] && idx >= inv_upto && m_cnt == 0;
    end
    check("dout", dout, ed);
    check("dout_valid", dout_valid, ev);
    check("busy", busy, m_cnt != 0);
    check("dly_cur", dly_cur, m_dly);
  endtask
  task automatic cyc(input bit e, input logic [CW-1:0] d, input bit v, input bit ld = 0, input int dl = 0);
    en = e; din = d; din_valid = v; dly_ld = ld; dly = DW'(dl);
    @(posedge clk);
    if (e) begin
      hist_d.push_back(d);
      hist_v.push_back(v);
    end
    if (ld) begin
      inv_upto = hist_d.size();
      m_cnt    = clampm(dl);
      m_dly    = m_cnt;
    end else if (e && m_cnt > 0) m_cnt--;
    #1;
    check_outs();
  endtask
  task automatic default_stream(input string tag);
    cyc(1, rep(8'h11), 1);
    cyc(1, rep(8'h22), 1);
    cyc(1, rep(8'h33), 1);
    check({tag, "_11"}, {dout_valid, dout[7:0]}, 9'h111);
    cyc(1, '0, 0);
    check({tag, "_22"}, {dout_valid, dout[7:0]}, 9'h122);
    cyc(1, '0, 0);
    check({tag, "_33"}, {dout_valid, dout[7:0]}, 9'h133);
  endtask
  initial begin
    logic [CW-1:0] held;
    bit            seen;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outs();
    reset_n = 1'b1;
    default_stream("def");
    // Stall in the middle of a stream
    cyc(1, rep(8'h44), 1);
    cyc(1, rep(8'h55), 1);
    held = dout;
    for (int i = 0; i < 4; i++) begin
      cyc(0, CW'($urandom), 1'($urandom));
      check("stall_hold", dout, held);
    end
    cyc(1, rep(8'h66), 1);
    for (int i = 0; i < 3; i++) cyc(1, '0, 0);
    // Reload to the maximum delay
    cyc(1, '0, 0, 1, 16);
    cyc(1, rep(8'hA5), 1);
    for (int i = 0; i < 14; i++) begin
      cyc(1, '0, 0);
      check("reload_busy", {busy, dout_valid}, 2'b10);
    end
    cyc(1, '0, 0);
    check("reload_emerge", {busy, dout_valid, dout}, {2'b01, rep(8'hA5)});
    // Clamping at both ends
    cyc(1, '0, 0, 1, 0);
    check("clamp_lo", dly_cur, 1);
    cyc(1, rep(8'h44), 1);
    check("clamp_lo_lat", {dout_valid, dout}, {1'b1, rep(8'h44)});
    cyc(1, '0, 0, 1, 20);
    check("clamp_hi", dly_cur, 16);
    // Sample arriving with a load is discarded
    cyc(1, rep(8'h7E), 1, 1, 3);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, '0, 0);
      if (dout_valid && dout[7:0] == 8'h7E) seen = 1'b1;
    end
    check("collision", seen, 0);
    // Asynchronous reset while samples are in flight
    cyc(1, '0, 0, 1, 6);
    for (int i = 0; i < 5; i++) cyc(1, rep(8'(8'h81 + i)), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_now", {dout, dout_valid, busy}, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_dly", dly_cur, DLY_RST);
    default_stream("post_rst");
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end else begin
        cyc($urandom_range(0, 3) != 0, CW'($urandom), 1'($urandom),
            $urandom_range(0, 24) == 0, int'($urandom_range(0, 31)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
